// File: rtl/dmem_arbiter.sv
`default_nettype none
// =====================================================================
// Module   : dmem_arbiter
// Brief    : Two-port arbiter/sequencer for the single-port data memory.
//            Round-robin tie-break when DMEM_ARB_RR_EN is defined,
//            fixed priority (port 0 wins) otherwise.
// Revision : 1.0 - initial release
// =====================================================================
module dmem_arbiter #(
   parameter int MEM_LAT = 1,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              stall0,
   output logic              mem_active,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int                 c_CNT_W    = $clog2(MEM_LAT) + 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LAT - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_we;
   logic                r_id;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [c_CNT_W-1:0] r_cnt;
   logic [DATA_W-1:0]   r_rdata;
   logic                w_any_req;
   logic                w_grant_id;
   logic                w_done;

   assign w_any_req = req0 | req1;
   assign w_done    = (r_cnt == '0);

`ifdef DMEM_ARB_RR_EN
   logic r_last_grant;

   // On a tie the port that did not win last time is served.
   always_comb begin
      if (req0 && req1) w_grant_id = ~r_last_grant;
      else              w_grant_id = ~req0;
   end

   always_ff @(posedge clk) begin
      if (reset)                              r_last_grant <= 1'b1;
      else if (r_state == S_IDLE && w_any_req) r_last_grant <= w_grant_id;
   end
`else
   assign w_grant_id = ~req0;
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      ack0       = 1'b0;
      ack1       = 1'b0;
      mem_active = 1'b0;
      mem_rw     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (r_state)
         S_IDLE: if (w_any_req) w_next = S_BUSY;
         S_BUSY: begin
            mem_active = 1'b1;
            mem_rw     = r_we;
            mem_addr   = r_addr;
            mem_wdata  = r_wdata;
            if (w_done) w_next = S_ACK;
         end
         S_ACK: begin
            ack0   = ~r_id;
            ack1   = r_id;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Request fields are only sampled at grant time; later changes are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_we    <= 1'b0;
         r_id    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_any_req) begin
               r_id    <= w_grant_id;
               r_we    <= w_grant_id ? we1    : we0;
               r_addr  <= w_grant_id ? addr1  : addr0;
               r_wdata <= w_grant_id ? wdata1 : wdata0;
               r_cnt   <= c_CNT_LOAD;
            end
            S_BUSY: begin
               if (!w_done)         r_cnt   <= r_cnt - c_CNT_ONE;
               if (w_done && !r_we) r_rdata <= mem_rdata;
            end
            default: ;
         endcase
      end
   end

   assign rdata  = r_rdata;
   assign stall0 = req0 & ~ack0;

endmodule
`default_nettype wire
